mul_exu: RTL

//   Pipelined RV32M multiply execution unit: accepts MUL/MULH/MULHSU/MULHU ops from the mul

---
 rtl/mul_exu.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mul_exu.sv
// rtl/mul_exu.sv - pipelined RV32M multiply unit between the mul reservation station and the CDB arbiter
module mul_exu #(
    parameter int TAG_WIDTH = 6,
    parameter int STAGES    = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_kill,
    input  logic                 i_issue_valid,
    output logic                 o_issue_ready,
    input  logic [2:0]           i_funct3,
    input  logic [31:0]          i_src1,
    input  logic [31:0]          i_src2,
    input  logic [TAG_WIDTH-1:0] i_tag,
    output logic                 o_cdb_valid,
    input  logic                 i_cdb_ready,
    output logic [31:0]          o_cdb_data,
    output logic [TAG_WIDTH-1:0] o_cdb_tag
);

    logic                 stall;
    logic                 dec_signed1;
    logic                 dec_signed2;
    logic                 dec_high;
    logic                 unused_funct3_msb;

    logic                 s1_valid;
    logic [TAG_WIDTH-1:0] s1_tag;
    logic                 s1_signed1;
    logic                 s1_signed2;
    logic                 s1_high;
    logic [31:0]          s1_src1;
    logic [31:0]          s1_src2;

    logic signed [63:0]   op_a;
    logic signed [63:0]   op_b;
    logic signed [63:0]   product;
    logic [31:0]          mul_result;

    // The whole pipeline freezes only while the head result waits for the CDB.
    assign stall             = o_cdb_valid & ~i_cdb_ready;
    assign o_issue_ready     = ~stall;
    assign unused_funct3_msb = i_funct3[2];

    always_comb begin
        dec_signed1 = 1'b1;
        dec_signed2 = 1'b1;
        dec_high    = 1'b1;
        case (i_funct3[1:0])
            2'b00:   dec_high = 1'b0;
            2'b01:   dec_high = 1'b1;
            2'b10:   dec_signed2 = 1'b0;
            default: begin
                dec_signed1 = 1'b0;
                dec_signed2 = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid   <= 1'b0;
            s1_tag     <= '0;
            s1_signed1 <= 1'b0;
            s1_signed2 <= 1'b0;
            s1_high    <= 1'b0;
            s1_src1    <= '0;
            s1_src2    <= '0;
        end else begin
            if (i_kill) begin
                s1_valid <= 1'b0;
            end else if (!stall) begin
                s1_valid <= i_issue_valid;
            end
            if (!stall) begin
                s1_tag     <= i_tag;
                s1_signed1 <= dec_signed1;
                s1_signed2 <= dec_signed2;
                s1_high    <= dec_high;
                s1_src1    <= i_src1;
                s1_src2    <= i_src2;
            end
        end
    end

    // 33-bit sign/zero extension widened to 64; the low 64 bits of the product are exact.
    assign op_a       = {{32{s1_signed1 & s1_src1[31]}}, s1_src1};
    assign op_b       = {{32{s1_signed2 & s1_src2[31]}}, s1_src2};
    assign product    = op_a * op_b;
    assign mul_result = s1_high ? product[63:32] : product[31:0];

    if (STAGES == 1) begin : g_single
        assign o_cdb_valid = s1_valid;
        assign o_cdb_tag   = s1_tag;
        assign o_cdb_data  = mul_result;
    end else begin : g_pipe
        logic [STAGES-1:1]    pv;
        logic [TAG_WIDTH-1:0] pt [1:STAGES-1];
        logic [31:0]          pr [1:STAGES-1];

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                pv <= '0;
                for (int k = 1; k < STAGES; k++) begin
                    pt[k] <= '0;
                    pr[k] <= '0;
                end
            end else begin
                if (i_kill) begin
                    pv <= '0;
                end else if (!stall) begin
                    pv[1] <= s1_valid;
                    for (int k = 2; k < STAGES; k++) begin
                        pv[k] <= pv[k-1];
                    end
                end
                if (!stall) begin
                    pt[1] <= s1_tag;
                    pr[1] <= mul_result;
                    for (int k = 2; k < STAGES; k++) begin
                        pt[k] <= pt[k-1];
                        pr[k] <= pr[k-1];
                    end
                end
            end
        end

        assign o_cdb_valid = pv[STAGES-1];
        assign o_cdb_tag   = pt[STAGES-1];
        assign o_cdb_data  = pr[STAGES-1];
    end

endmodule
